bullet_controller: RTL and testbench
====================================

// Module: bullet_controller
// PURPOSE
//  Owns one tank's bullet: launches it from the tank muzzle on a fire request, advances it once
//  per video frame in the direction latched at launch, and retires it at a screen edge or on a hit.
//  Produces bullet_X/bullet_Y and the per-pixel is_bullet strobe consumed by color_mapper.
//  Sits between the keycode/tank logic and color_mapper; one instance per tank.
// PARAMETERS
//  BulletSize  16   bullet sprite edge in pixels (matches the 16x16 bullet frame RAM)
//  TankSize    32   tank sprite edge in pixels
//  Step        4    pixels moved per frame tick
//  ScreenW     640  visible width;  ScreenH 480 visible height
//  CoolFrames  8    frame ticks after retirement before the next launch is accepted
// PORTS
//  Clk           in   1   system clock
//  Reset_n       in   1   asynchronous reset, active low
//  frame_clk     in   1   VGA vsync-derived frame strobe, asynchronous to Clk
//  fire          in   1   level fire request from keycode decode
//  hit           in   1   collision flag (wall or enemy tank); level, sampled on frame tick
//  tank_dir      in   3   001 up, 010 right, 011 left, 100 down; other codes are invalid
//  tankX, tankY  in   10  tank top-left corner
//  DrawX, DrawY  in   10  current pixel coordinates
//  bullet_X      out  10  bullet top-left X
//  bullet_Y      out  10  bullet top-left Y
//  bullet_active out  1   bullet in flight
//  is_bullet     out  1   current pixel lies inside the active bullet box
// BEHAVIOUR
//  Reset (Reset_n=0, async): state IDLE; bullet_X, bullet_Y, cooldown count, latched dir = 0;
//   bullet_active = 0, is_bullet = 0. Reset mid-flight retires the bullet immediately.
//  Frame tick: frame_clk goes through a 2-flop synchroniser in Clk; tick = 1-Clk pulse on the
//   rising edge of the synchronised signal. All state changes below happen only on tick.
//  FSM:
//   IDLE: fire=1 and tank_dir valid -> compute spawn (off = (TankSize-BulletSize)/2 = 8):
//    up    X=tankX+8,  Y=tankY-16;     down  X=tankX+8,  Y=tankY+32
//    left  X=tankX-16, Y=tankY+8;      right X=tankX+32, Y=tankY+8
//    Spawn box not fully on screen (e.g. tankY<16 for up; tankX+48>ScreenW for right)
//     -> stay IDLE, no launch. Otherwise load X/Y, latch dir, go FLY.
//    fire=0 or invalid tank_dir -> stay IDLE.
//   FLY (bullet_active=1): priority is hit > edge > move.
//    hit=1 -> COOL.
//    Edge: next step would leave the screen -> COOL. Conditions: up Y<Step; left X<Step;
//     down Y+BulletSize+Step>ScreenH; right X+BulletSize+Step>ScreenW. Compare at >=11-bit
//     width, no wrap.
//    Else add or subtract Step on the latched axis. tank_dir and tank motion have no effect
//     after launch. fire is ignored while in FLY.
//   COOL: bullet_active=0; X/Y hold their last values; counter counts ticks 0..CoolFrames-1,
//    then IDLE. fire is ignored in COOL. A launch is allowed on the first tick seen in IDLE.
//  is_bullet: combinational from registers, zero latency.
//   is_bullet = bullet_active && DrawX>=X && DrawX<X+BulletSize && DrawY>=Y && DrawY<Y+BulletSize.
//  Latency: fire asserted before tick N -> bullet_active=1 and spawn X/Y visible 1 Clk after tick N.
// TESTING
//  1 Reset_n=0 during FLY -> all outputs 0 immediately (async); IDLE after release.
//  2 tankX=100, tankY=200, dir=010, fire, 1 tick -> X=132, Y=208, active=1;
//    after 3 more ticks -> X=144.
//  3 dir=001, tankY=20, fire -> spawn Y=4; on next tick (4<Step fails? Y=4 equals Step, moves) Y=0;
//    on the tick after -> COOL, active=0; after 8 more ticks -> IDLE, refire accepted.
//  4 Up-spawn edge: tankY=10, dir=001, fire held for 5 ticks -> no launch, active stays 0.
//  5 FLY, hit=1 on the same tick the edge is reached -> COOL (hit priority); X/Y unchanged.
//  6 Bullet at (300,100) active: DrawX/DrawY = (300,100)->1, (315,115)->1, (316,100)->0,
//    (299,100)->0; after retirement -> 0 everywhere.

Source files
------------

// File: rtl/bullet_controller.sv
// Single-bullet controller for one tank: launches from the muzzle, steps once per frame tick,
// retires at a screen edge or on a hit, then waits out a cooldown before the next launch.
module bullet_controller #(
  parameter int BulletSize = 16,
  parameter int TankSize   = 32,
  parameter int Step       = 4,
  parameter int ScreenW    = 640,
  parameter int ScreenH    = 480,
  parameter int CoolFrames = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       hit,
  input  logic [2:0] tank_dir,
  input  logic [9:0] tankX,
  input  logic [9:0] tankY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] bullet_X,
  output logic [9:0] bullet_Y,
  output logic       bullet_active,
  output logic       is_bullet
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FLY  = 2'd1;
  localparam logic [1:0] COOL = 2'd2;

  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_DOWN  = 3'b100;

  localparam logic [11:0] BS  = 12'(BulletSize);
  localparam logic [11:0] TS  = 12'(TankSize);
  localparam logic [11:0] OFF = 12'((TankSize - BulletSize) / 2);
  localparam logic [11:0] ST  = 12'(Step);
  localparam logic [11:0] SW  = 12'(ScreenW);
  localparam logic [11:0] SH  = 12'(ScreenH);

  localparam int CW = $clog2(CoolFrames + 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(CoolFrames - 1);

  logic [1:0]    state;
  logic [2:0]    dir_q;
  logic [CW-1:0] cool_cnt;
  logic          frame_q1, frame_q2, frame_q3;
  logic          tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q1 <= 1'b0;
      frame_q2 <= 1'b0;
      frame_q3 <= 1'b0;
    end else begin
      frame_q1 <= frame_clk;
      frame_q2 <= frame_q1;
      frame_q3 <= frame_q2;
    end
  end

  assign tick = frame_q2 & ~frame_q3;

  logic [11:0] tx, ty, bx, by, sx, sy;
  logic        spawn_ok, side_ok, dir_valid, at_edge;

  assign tx = {2'b00, tankX};
  assign ty = {2'b00, tankY};
  assign bx = {2'b00, bullet_X};
  assign by = {2'b00, bullet_Y};

  // Underflow on the subtracted axis is screened before the on-screen box test.
  always_comb begin
    sx        = '0;
    sy        = '0;
    side_ok   = 1'b0;
    dir_valid = 1'b1;
    case (tank_dir)
      DIR_UP:    begin sx = tx + OFF; sy = ty - BS;  side_ok = (ty >= BS); end
      DIR_DOWN:  begin sx = tx + OFF; sy = ty + TS;  side_ok = 1'b1;       end
      DIR_LEFT:  begin sx = tx - BS;  sy = ty + OFF; side_ok = (tx >= BS); end
      DIR_RIGHT: begin sx = tx + TS;  sy = ty + OFF; side_ok = 1'b1;       end
      default:   dir_valid = 1'b0;
    endcase
    spawn_ok = dir_valid && side_ok && (sx + BS <= SW) && (sy + BS <= SH);
  end

  always_comb begin
    case (dir_q)
      DIR_UP:    at_edge = (by < ST);
      DIR_LEFT:  at_edge = (bx < ST);
      DIR_DOWN:  at_edge = (by + BS + ST > SH);
      DIR_RIGHT: at_edge = (bx + BS + ST > SW);
      default:   at_edge = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      dir_q    <= '0;
      cool_cnt <= '0;
      bullet_X <= '0;
      bullet_Y <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (fire && spawn_ok) begin
            bullet_X <= sx[9:0];
            bullet_Y <= sy[9:0];
            dir_q    <= tank_dir;
            state    <= FLY;
          end
        end
        FLY: begin
          if (hit || at_edge) begin
            cool_cnt <= '0;
            state    <= COOL;
          end else begin
            case (dir_q)
              DIR_UP:    bullet_Y <= bullet_Y - 10'(Step);
              DIR_DOWN:  bullet_Y <= bullet_Y + 10'(Step);
              DIR_LEFT:  bullet_X <= bullet_X - 10'(Step);
              default:   bullet_X <= bullet_X + 10'(Step);
            endcase
          end
        end
        COOL: begin
          if (cool_cnt == COOL_LAST) begin
            cool_cnt <= '0;
            state    <= IDLE;
          end else begin
            cool_cnt <= cool_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bullet_active = (state == FLY);

  logic [11:0] dx, dy;
  assign dx = {2'b00, DrawX};
  assign dy = {2'b00, DrawY};

  assign is_bullet = bullet_active && (dx >= bx) && (dx < bx + BS) &&
                     (dy >= by) && (dy < by + BS);

endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: directed stimulus queues hand-computed outputs,
// an independent monitor pops and compares them on the falling clock edge.
module tb_bullet_controller;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       fire;
  logic       hit;
  logic [2:0] tank_dir;
  logic [9:0] tankX, tankY, DrawX, DrawY;
  logic [9:0] bullet_X, bullet_Y;
  logic       bullet_active, is_bullet;

  bullet_controller #(
    .BulletSize(16), .TankSize(32), .Step(4),
    .ScreenW(640), .ScreenH(480), .CoolFrames(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire), .hit(hit),
    .tank_dir(tank_dir), .tankX(tankX), .tankY(tankY), .DrawX(DrawX), .DrawY(DrawY),
    .bullet_X(bullet_X), .bullet_Y(bullet_Y), .bullet_active(bullet_active),
    .is_bullet(is_bullet)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic       a;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (bullet_X !== e.x || bullet_Y !== e.y || bullet_active !== e.a || is_bullet !== e.b) begin
          miscompares++;
          $display("FAIL %s: got X=%0d Y=%0d active=%b is_bullet=%b, want X=%0d Y=%0d active=%b is_bullet=%b",
                   e.name, bullet_X, bullet_Y, bullet_active, is_bullet, e.x, e.y, e.a, e.b);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int x, input int y, input logic a, input logic b);
    exp_t e;
    int   wait_cyc;
    e.name = name; e.x = 10'(x); e.y = 10'(y); e.a = a; e.b = b;
    exp_q.push_back(e);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge Clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      vectors++;
      $display("FAIL %s: monitor did not consume expectation within 20 cycles", name);
      exp_q.delete();
    end
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic launch(input logic [2:0] d, input int x, input int y);
    tank_dir = d; tankX = 10'(x); tankY = 10'(y); fire = 1'b1;
    do_tick();
    fire = 1'b0;
  endtask

  task automatic pixel(input string name, input int px, input int py, input int bx, input int by,
                       input logic a, input logic b);
    @(negedge Clk);
    DrawX = 10'(px); DrawY = 10'(py);
    expect_out(name, bx, by, a, b);
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; hit = 1'b0;
    tank_dir = 3'b000; tankX = '0; tankY = '0; DrawX = '0; DrawY = '0;
    repeat (3) @(negedge Clk);
    expect_out("reset_state", 0, 0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // right launch and motion
    launch(3'b010, 100, 200);
    expect_out("right_spawn", 132, 208, 1'b1, 1'b0);
    ticks(3);
    expect_out("right_move3", 144, 208, 1'b1, 1'b0);

    // async reset mid-flight
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    expect_out("async_reset_fly", 0, 0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    do_tick();
    expect_out("idle_after_reset", 0, 0, 1'b0, 1'b0);

    // up launch, edge retirement, cooldown boundary (fire held throughout)
    tank_dir = 3'b001; tankX = 10'd100; tankY = 10'd20; fire = 1'b1;
    do_tick();
    expect_out("up_spawn_y4", 108, 4, 1'b1, 1'b0);
    tankY = 10'd200;
    do_tick();
    expect_out("up_move_y0", 108, 0, 1'b1, 1'b0);
    do_tick();
    expect_out("up_edge_cool", 108, 0, 1'b0, 1'b0);
    ticks(8);
    expect_out("cool_8_no_launch", 108, 0, 1'b0, 1'b0);
    do_tick();
    expect_out("refire_after_cool", 108, 184, 1'b1, 1'b0);
    fire = 1'b0;

    // hit mid-flight retires without moving
    hit = 1'b1;
    do_tick();
    hit = 1'b0;
    expect_out("hit_mid_flight", 108, 184, 1'b0, 1'b0);
    ticks(8);

    // up spawn off screen: no launch
    tank_dir = 3'b001; tankX = 10'd100; tankY = 10'd10; fire = 1'b1;
    ticks(5);
    fire = 1'b0;
    expect_out("up_spawn_blocked", 108, 184, 1'b0, 1'b0);

    // right spawn off screen: no launch
    tank_dir = 3'b010; tankX = 10'd608; tankY = 10'd100; fire = 1'b1;
    do_tick();
    fire = 1'b0;
    expect_out("right_spawn_blocked", 108, 184, 1'b0, 1'b0);

    // invalid direction: no launch
    tank_dir = 3'b111; tankX = 10'd100; tankY = 10'd100; fire = 1'b1;
    do_tick();
    fire = 1'b0;
    expect_out("invalid_dir", 108, 184, 1'b0, 1'b0);

    // right edge with hit on the same tick; tank motion ignored after launch
    launch(3'b010, 560, 100);
    expect_out("right_spawn_592", 592, 108, 1'b1, 1'b0);
    tank_dir = 3'b011; tankX = 10'd0;
    ticks(8);
    expect_out("right_last_step_624", 624, 108, 1'b1, 1'b0);
    hit = 1'b1;
    do_tick();
    hit = 1'b0;
    expect_out("hit_at_edge", 624, 108, 1'b0, 1'b0);
    ticks(8);

    // left edge
    launch(3'b011, 20, 50);
    expect_out("left_spawn", 4, 58, 1'b1, 1'b0);
    do_tick();
    expect_out("left_move_x0", 0, 58, 1'b1, 1'b0);
    do_tick();
    expect_out("left_edge_cool", 0, 58, 1'b0, 1'b0);
    ticks(8);

    // down edge
    launch(3'b100, 50, 428);
    expect_out("down_spawn", 58, 460, 1'b1, 1'b0);
    do_tick();
    expect_out("down_move_464", 58, 464, 1'b1, 1'b0);
    do_tick();
    expect_out("down_edge_cool", 58, 464, 1'b0, 1'b0);
    ticks(8);

    // is_bullet box
    launch(3'b010, 268, 92);
    expect_out("box_spawn", 300, 100, 1'b1, 1'b0);
    pixel("pix_300_100", 300, 100, 300, 100, 1'b1, 1'b1);
    pixel("pix_315_115", 315, 115, 300, 100, 1'b1, 1'b1);
    pixel("pix_316_100", 316, 100, 300, 100, 1'b1, 1'b0);
    pixel("pix_299_100", 299, 100, 300, 100, 1'b1, 1'b0);
    pixel("pix_300_116", 300, 116, 300, 100, 1'b1, 1'b0);
    hit = 1'b1;
    do_tick();
    hit = 1'b0;
    pixel("pix_retired", 300, 100, 300, 100, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
